// File: rtl/mem_access_unit_if.sv
// Bundle of the CPU-side and memory-side signals of the data access unit.
// master: the access unit itself; slave: the CPU/memory environment around it.
interface mem_access_unit_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic [1:0]  cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  cpu_valid, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_ready, cpu_rdata, cpu_done, cpu_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output cpu_valid, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rdata, cpu_done, cpu_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-side load/store unit: lane steering, byte enables, load extension,
// single outstanding req/ack access with misalignment and timeout errors.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_unit_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StCheck, StReq, StDone} state_e;

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrAlign   = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  state_e           state_q;
  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             done_q;
  logic [1:0]       err_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_wdata_q;

  logic             misaligned;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [7:0]       load_byte;
  logic [15:0]      load_half;
  logic [31:0]      load_ext;

  always_comb begin
    misaligned = (size_q == 2'b11) ||
                 (size_q == 2'b01 && addr_q[0]) ||
                 (size_q == 2'b10 && addr_q[1:0] != 2'b00);

    lane_be    = 4'b0000;
    lane_wdata = wdata_q;
    case (size_q)
      2'b00: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
      end
      default: begin
        lane_be    = 4'b0000;
        lane_wdata = wdata_q;
      end
    endcase

    // Little-endian lane pick from the returned word.
    load_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & load_byte[7]}}, load_byte};
      2'b01:   load_ext = {{16{~uns_q & load_half[15]}}, load_half};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      cnt_q       <= '0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= ErrOk;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.cpu_valid) begin
            we_q    <= bus.cpu_we;
            size_q  <= bus.cpu_size;
            uns_q   <= bus.cpu_unsigned;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (misaligned) begin
            done_q  <= 1'b1;
            err_q   <= ErrAlign;
            state_q <= StDone;
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= we_q;
            mem_addr_q  <= {addr_q[31:2], 2'b00};
            mem_be_q    <= lane_be;
            mem_wdata_q <= lane_wdata;
            cnt_q       <= '0;
            state_q     <= StReq;
          end
        end
        StReq: begin
          // Ack beats timeout when both land in the same cycle.
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= ErrOk;
            if (!we_q) rdata_q <= load_ext;
            state_q   <= StDone;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= ErrTimeout;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          err_q   <= ErrOk;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cpu_ready = (state_q == StIdle);
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_done  = done_q;
  assign bus.cpu_err   = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table with a scoreboard of expected completions,
// plus hand-written reset, late-ack and busy-request sequences.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          wait_cyc;  // REQ cycles before ack; -1 = never
    logic [1:0]  err;
    logic [31:0] rdata;     // only meaningful for loads that complete ok
    logic [3:0]  be;
    logic [31:0] mwdata;    // only meaningful for stores
    int          lat;       // done cycle, counting the accept cycle as 0
  } vec_t;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  vec_t        vecs[17];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mrdata, input int wait_cyc,
                              input logic [1:0] err, input logic [31:0] rdata,
                              input logic [3:0] be, input logic [31:0] mwdata, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.mrdata = mrdata; v.wait_cyc = wait_cyc; v.err = err; v.rdata = rdata;
    v.be = be; v.mwdata = mwdata; v.lat = lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    exp_t        e;
    exp_t        got;
    int          cyc;
    int          reqc;
    logic        seen_req;
    logic        stable;
    logic        done_seen;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic [3:0]  be0;
    logic        we0;
    string       tag;
    tag = $sformatf("v%0d", idx);

    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.cpu_ready), 32'd1);
    bus.cpu_valid    = 1'b1;
    bus.cpu_we       = v.we;
    bus.cpu_size     = v.size;
    bus.cpu_unsigned = v.uns;
    bus.cpu_addr     = v.addr;
    bus.cpu_wdata    = v.wdata;
    bus.mem_rdata    = v.mrdata;
    if (!v.we && v.err == 2'b00) model_rdata = v.rdata;
    e.err = v.err; e.rdata = model_rdata; e.lat = v.lat;
    sb.push_back(e);

    @(posedge clk);
    #1;
    // Keep cpu_valid high with junk while busy; it must not be latched.
    bus.cpu_addr  = 32'hFFFF_FFF1;
    bus.cpu_size  = 2'b11;
    bus.cpu_we    = ~v.we;
    bus.cpu_wdata = 32'h5A5A_5A5A;

    cyc = 1; reqc = 0; seen_req = 1'b0; stable = 1'b1; done_seen = 1'b0;
    a0 = '0; wd0 = '0; be0 = '0; we0 = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      if (bus.cpu_done) begin
        done_seen = 1'b1;
        break;
      end
      if (bus.cpu_ready) stable = 1'b0;
      if (bus.mem_req) begin
        if (!seen_req) begin
          a0 = bus.mem_addr; wd0 = bus.mem_wdata; be0 = bus.mem_be; we0 = bus.mem_we;
        end else if (a0 !== bus.mem_addr || wd0 !== bus.mem_wdata ||
                     be0 !== bus.mem_be || we0 !== bus.mem_we) begin
          stable = 1'b0;
        end
        seen_req = 1'b1;
        bus.mem_ack = (v.wait_cyc >= 0 && reqc == v.wait_cyc);
        reqc++;
      end
      @(posedge clk);
      #1 bus.mem_ack = 1'b0;
      cyc++;
    end
    bus.cpu_valid = 1'b0;

    check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    got = sb.pop_front();
    if (done_seen) begin
      check({tag, "_err"}, 32'(bus.cpu_err), 32'(got.err));
      check({tag, "_rdata"}, bus.cpu_rdata, got.rdata);
      check({tag, "_latency"}, 32'(cyc), 32'(got.lat));
      check({tag, "_req_low_at_done"}, 32'(bus.mem_req), 32'd0);
    end
    check({tag, "_busy_ok"}, 32'(stable), 32'd1);
    check({tag, "_req_seen"}, 32'(seen_req), 32'(v.err != 2'b01));
    if (seen_req) begin
      check({tag, "_mem_addr"}, a0, {v.addr[31:2], 2'b00});
      check({tag, "_mem_be"}, 32'(be0), 32'(v.be));
      check({tag, "_mem_we"}, 32'(we0), 32'(v.we));
      if (v.we) check({tag, "_mem_wdata"}, wd0, v.mwdata);
    end

    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(bus.cpu_done), 32'd0);
    check({tag, "_err_clear"}, 32'(bus.cpu_err), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.cpu_ready), 32'd1);
  endtask

  initial begin
    int          n;
    logic        any_done;
    logic        got_req;

    // Load results: 0x2001 lane1 of 0x1234F678 is 0xF6; 0x2002 upper half of 0x80010000 is 0x8001.
    vecs[0]  = mk(1, 2'b00, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 2'b00, 32'h0, 4'b1000,
                  32'hABAB_ABAB, 3);
    vecs[1]  = mk(0, 2'b00, 0, 32'h0000_2001, 32'h0, 32'h1234_F678, 0, 2'b00, 32'hFFFF_FFF6,
                  4'b0010, 32'h0, 3);
    vecs[2]  = mk(0, 2'b00, 1, 32'h0000_2001, 32'h0, 32'h1234_F678, 0, 2'b00, 32'h0000_00F6,
                  4'b0010, 32'h0, 3);
    vecs[3]  = mk(0, 2'b01, 0, 32'h0000_2002, 32'h0, 32'h8001_0000, 4, 2'b00, 32'hFFFF_8001,
                  4'b1100, 32'h0, 7);
    vecs[4]  = mk(0, 2'b01, 1, 32'h0000_2002, 32'h0, 32'h8001_0000, 4, 2'b00, 32'h0000_8001,
                  4'b1100, 32'h0, 7);
    vecs[5]  = mk(0, 2'b01, 0, 32'h0000_3001, 32'h0, 32'hFFFF_FFFF, 0, 2'b01, 32'h0, 4'b0000,
                  32'h0, 2);
    vecs[6]  = mk(0, 2'b10, 0, 32'h0000_3002, 32'h0, 32'hFFFF_FFFF, 0, 2'b01, 32'h0, 4'b0000,
                  32'h0, 2);
    vecs[7]  = mk(1, 2'b11, 0, 32'h0000_3000, 32'h1, 32'hFFFF_FFFF, 0, 2'b01, 32'h0, 4'b0000,
                  32'h0, 2);
    vecs[8]  = mk(0, 2'b10, 0, 32'h0000_4000, 32'h0, 32'h7777_7777, -1, 2'b10, 32'h0, 4'b1111,
                  32'h0, 18);
    vecs[9]  = mk(0, 2'b10, 0, 32'h0000_4004, 32'h0, 32'hDEAD_BEEF, 0, 2'b00, 32'hDEAD_BEEF,
                  4'b1111, 32'h0, 3);
    vecs[10] = mk(1, 2'b01, 0, 32'h0000_5002, 32'hFFFF_1234, 32'h0, 1, 2'b00, 32'h0, 4'b1100,
                  32'h1234_1234, 4);
    vecs[11] = mk(1, 2'b10, 0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 2, 2'b00, 32'h0, 4'b1111,
                  32'hCAFE_F00D, 5);
    vecs[12] = mk(0, 2'b00, 0, 32'h0000_6003, 32'h0, 32'h7F00_0000, 0, 2'b00, 32'h0000_007F,
                  4'b1000, 32'h0, 3);
    vecs[13] = mk(0, 2'b01, 0, 32'h0000_6000, 32'h0, 32'h0000_ABCD, 0, 2'b00, 32'hFFFF_ABCD,
                  4'b0011, 32'h0, 3);
    vecs[14] = mk(1, 2'b00, 0, 32'h0000_7000, 32'h1234_56C3, 32'h0, 0, 2'b00, 32'h0, 4'b0001,
                  32'hC3C3_C3C3, 3);
    vecs[15] = mk(1, 2'b00, 0, 32'h0000_7002, 32'h0000_0099, 32'h0, 0, 2'b00, 32'h0, 4'b0100,
                  32'h9999_9999, 3);
    // Ack lands in the final allowed REQ cycle: must complete ok, not time out.
    vecs[16] = mk(0, 2'b10, 0, 32'h0000_8000, 32'h0, 32'h0102_0304, 15, 2'b00, 32'h0102_0304,
                  4'b1111, 32'h0, 18);

    bus.cpu_valid = 0; bus.cpu_we = 0; bus.cpu_size = 0; bus.cpu_unsigned = 0;
    bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    model_rdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.cpu_ready), 32'd1);
    check("rst_done", 32'(bus.cpu_done), 32'd0);
    check("rst_err", 32'(bus.cpu_err), 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'h0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Timeout followed by a late ack while idle, then a normal load.
    run_vec(vecs[8], 100);
    any_done = 1'b0;
    bus.mem_rdata = 32'hBAD0_BAD0;
    bus.mem_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.cpu_done || bus.mem_req) any_done = 1'b1;
    end
    bus.mem_ack = 1'b0;
    check("late_ack_ignored", 32'(any_done), 32'd0);
    check("late_ack_rdata", bus.cpu_rdata, model_rdata);
    run_vec(vecs[13], 101);

    // Reset in the middle of a REQ: abandon silently.
    @(negedge clk);
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b10; bus.cpu_addr = 32'h0000_9000;
    got_req = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      bus.cpu_valid = 1'b0;
      if (bus.mem_req) begin
        got_req = 1'b1;
        break;
      end
      n++;
    end
    check("rstreq_req_seen", 32'(got_req), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_rdata = 32'h0;
    check("rstreq_mem_req", 32'(bus.mem_req), 32'd0);
    check("rstreq_ready", 32'(bus.cpu_ready), 32'd1);
    check("rstreq_rdata", bus.cpu_rdata, 32'h0);
    check("rstreq_done", 32'(bus.cpu_done), 32'd0);
    any_done = 1'b0;
    bus.mem_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.cpu_done || bus.mem_req) any_done = 1'b1;
    end
    bus.mem_ack = 1'b0;
    check("rstreq_no_done", 32'(any_done), 32'd0);
    run_vec(vecs[1], 102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-side memory access unit between the CPU's load/store stage and a word-wide data memory with a req/ack handshake.
- Store path: narrows a 32-bit register value to byte/halfword, replicates it into the addressed lane and generates byte enables.
- Load path: extracts the addressed lane from the returned word and sign- or zero-extends it to 32 bits.
- Multi-cycle: one access in flight, little-endian, with misalignment and timeout error reporting.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before abort (>=1)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
cpu_valid  input  1  access request from CPU
cpu_ready  output  1  unit idle, request accepted this cycle if cpu_valid=1
cpu_we  input  1  1=store, 0=load
cpu_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
cpu_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend
cpu_addr  input  32  byte address
cpu_wdata  input  32  store data, right-justified
cpu_rdata  output  32  extended load result
cpu_done  output  1  one-cycle completion pulse
cpu_err  output  2  valid with cpu_done: 00 ok, 01 misaligned/illegal size, 10 timeout
mem_req  output  1  memory request, held until ack
mem_we  output  1  write strobe qualifier
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  memory completion, sampled only while mem_req=1
mem_rdata  input  32  read word, valid in ack cycle

Behaviour:
- States: IDLE, CHECK, REQ, DONE. All outputs registered, except cpu_ready = (state==IDLE).
- Reset (synchronous, any state):
  - state -> IDLE; cpu_rdata=0, cpu_done=0, cpu_err=00.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0; timeout counter=0.
  - An in-flight access is abandoned silently with no done pulse.
- IDLE: on cpu_valid=1, latch we/size/unsigned/addr/wdata and go to CHECK. cpu_valid in any other state is ignored, not queued.
- CHECK (one cycle): access is misaligned if any of these holds:
  - size=11;
  - size=01 and addr[0]=1;
  - size=10 and addr[1:0]!=0.
  - Misaligned -> DONE with err=01; memory is never touched.
  - Otherwise drive mem_req=1, mem_we=we, mem_addr, mem_be, mem_wdata; counter=0; go to REQ.
- Byte enables and store data:
  - byte: be = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - word: be = 1111; wdata = wdata.
  - Loads drive the same be pattern, with mem_we=0.
- REQ:
  - mem_* outputs are held stable.
  - On mem_ack=1: drop mem_req/mem_we next edge, go to DONE with err=00.
  - Loads only, in the ack cycle, update cpu_rdata:
    - byte lane L=addr[1:0]: rdata[8L+7:8L], extended from bit 7.
    - half: rdata[16H+15:16H] with H=addr[1], extended from bit 15.
    - word: passed unchanged.
    - Sign extension replicates the top bit into upper bits; zero extension fills 0.
  - Stores leave cpu_rdata unchanged.
  - Without ack, counter increments. When counter reaches TIMEOUT-1 with no ack: drop mem_req, go to DONE with err=10; cpu_rdata unchanged.
  - mem_ack in the same cycle as timeout expiry wins (err=00).
- DONE: cpu_done=1 for exactly one cycle with cpu_err; next state IDLE. cpu_err returns to 00 after the pulse.
- Latency: accept at edge T, CHECK at T+1 with mem_req visible after it, ack at earliest in the cycle after, cpu_done high one cycle later.
  - Zero-wait access: done 3 cycles after accept.
  - Misaligned: done 2 cycles after accept.
- mem_ack while mem_req=0 (including a late ack after reset or timeout) is ignored.
- Back-to-back: cpu_ready returns high the cycle after cpu_done; the next request is accepted then.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000AB, ack immediate -> mem_addr=0x1000, be=1000, mem_wdata=0xABABABAB, mem_we=1, done err=00 exactly 3 cycles after accept.
- Load byte signed and unsigned: addr=0x2001, mem_rdata=0x1234F678 -> signed cpu_rdata=0xFFFFFFF6; with cpu_unsigned=1 -> 0x000000F6.
- Load half, addr=0x2002, mem_rdata=0x8001_0000, ack after 4 wait cycles:
  - signed -> cpu_rdata=0xFFFF8001, mem_req held stable throughout;
  - unsigned -> 0x00008001.
- Misalignment: half at 0x3001, word at 0x3002, size=11 -> each gives done with err=01, mem_req never asserted, cpu_rdata unchanged.
- Timeout: TIMEOUT=16, no ack -> mem_req drops, done err=10. A late ack afterwards is ignored; the next load completes normally.
- Reset while in REQ -> mem_req=0 and state IDLE next cycle, no cpu_done pulse, cpu_rdata=0; cpu_valid during busy states is never accepted.
